program_counter: RTL and testbench



---
 rtl/core_pkg.sv | 10 +
 rtl/program_counter.sv | 48 ++++
 tb/tb_program_counter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: address width, reset vector and address type.
package core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef logic [XLEN-1:0] addr_t;

endpackage : core_pkg

// File: rtl/program_counter.sv
// Program counter register for the single-cycle core.
// Holds the fetch address. Each rising edge loads pc_next verbatim, and a
// synchronous reset forces RESET_VECTOR instead.
// Optional build macro PC_MISALIGN_FLAG_EN adds a registered 'misaligned'
// debug flag that is set when the low two address bits are non-zero.
module program_counter #(
    parameter int unsigned            WIDTH        = core_pkg::XLEN,
    parameter logic [WIDTH-1:0]       RESET_VECTOR = WIDTH'(core_pkg::RESET_VECTOR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_next,
`ifdef PC_MISALIGN_FLAG_EN
    output logic             misaligned,
`endif
    output logic [WIDTH-1:0] curr_pc
);

    // The power-up value matches reset, so curr_pc is defined before the first edge.
    logic [WIDTH-1:0] pc_q = RESET_VECTOR;

    // PC register: reset has priority, otherwise load the datapath value unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign curr_pc = pc_q;

`ifdef PC_MISALIGN_FLAG_EN
    logic misaligned_q = 1'b0;

    // Alignment flag computed from the incoming value so it lines up with curr_pc.
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= (pc_next[1:0] != 2'b00);
        end
    end

    assign misaligned = misaligned_q;
`endif

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed test of program_counter with a scoreboard of expected PC values.
module tb_program_counter;

    localparam int unsigned W = core_pkg::XLEN;

    logic         clk;
    logic         reset;
    logic [W-1:0] pc_next;
    logic [W-1:0] curr_pc;
`ifdef PC_MISALIGN_FLAG_EN
    logic         misaligned;
`endif

    int unsigned  total;
    int unsigned  bad;

    core_pkg::addr_t exp_q[$];
`ifdef PC_MISALIGN_FLAG_EN
    logic            mis_q[$];
`endif

    program_counter #(
        .WIDTH        (W),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_next    (pc_next),
`ifdef PC_MISALIGN_FLAG_EN
        .misaligned (misaligned),
`endif
        .curr_pc    (curr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare a PC value against a bench-supplied expectation.
    task automatic check_pc(input string tag, input logic [W-1:0] exp);
        total++;
        assert (curr_pc === exp)
        else begin
            bad++;
            $error("FAIL %s: curr_pc=%h expected=%h", tag, curr_pc, exp);
        end
    endtask

    // Drive one edge, record expectations, then pop and compare after the edge.
    task automatic step(input string tag, input logic rst, input logic [W-1:0] nxt);
        core_pkg::addr_t e;
        reset   = rst;
        pc_next = nxt;
        exp_q.push_back(rst ? 32'h0000_0000 : nxt);
`ifdef PC_MISALIGN_FLAG_EN
        mis_q.push_back(rst ? 1'b0 : (nxt[1:0] != 2'b00));
`endif
        @(posedge clk);
        #1;
        total++;
        assert (exp_q.size() != 0)
        else begin
            bad++;
            $error("FAIL %s: scoreboard empty", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_pc(tag, e);
        end
`ifdef PC_MISALIGN_FLAG_EN
        if (mis_q.size() != 0) begin
            logic em;
            em = mis_q.pop_front();
            total++;
            assert (misaligned === em)
            else begin
                bad++;
                $error("FAIL %s_mis: misaligned=%b expected=%b", tag, misaligned, em);
            end
        end
`endif
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] r;
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        pc_next = 32'hDEAD_BEEF;

        // Power-up value before any edge.
        #1;
        check_pc("powerup", 32'h0000_0000);
`ifdef PC_MISALIGN_FLAG_EN
        total++;
        assert (misaligned === 1'b0)
        else begin
            bad++;
            $error("FAIL powerup_mis: misaligned=%b expected=0", misaligned);
        end
`endif

        step("reset_edge", 1'b1, 32'hDEAD_BEEF);
        step("reset_hold", 1'b1, 32'hDEAD_BEEF);
        step("release",    1'b0, 32'hDEAD_BEEF);

        // Consecutive random values, one per cycle.
        for (int i = 0; i < 4; i++) begin
            r = $urandom();
            step($sformatf("rand%0d", i), 1'b0, r);
        end

        step("all_ones",  1'b0, 32'hFFFF_FFFF);
        step("all_zeros", 1'b0, 32'h0000_0000);
        step("ones_again", 1'b0, 32'hFFFF_FFFF);

        // Mid-run reset, plus reset glitches between edges.
        step("pre_reset", 1'b0, 32'h0000_1000);
        pc_next = 32'h0000_1004;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #2;
        check_pc("glitch_hold", 32'h0000_1000);
        step("mid_reset",  1'b1, 32'h0000_1004);
        step("post_reset", 1'b0, 32'h0000_1008);

        // Low-bit patterns; these also exercise the alignment flag when present.
        step("low_bits6", 1'b0, 32'h0000_0006);
        step("low_bits8", 1'b0, 32'h0000_0008);
        step("low_bits1", 1'b0, 32'h0000_0001);
        step("reset_tail", 1'b1, 32'h0000_0003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_program_counter
